fetch_prefetch_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the single-cycle core's instruction path.
- Issues sequential word fetches to a multi-cycle instruction memory over a req/valid handshake.
- Buffers returned words with their PCs in a small FIFO, and presents them to the core through a valid/ready interface.
- Supports PC redirect (branch/jump) with flush, and discards any in-flight stale response.

---
 rtl/fetch_prefetch_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Instruction-fetch front end. It walks the PC sequentially and issues one word
// fetch at a time to a multi-cycle instruction memory. Returned words are queued
// with their PCs in a small FIFO and handed to the core over valid/ready.
// A redirect flushes the FIFO and restarts fetch at the new PC. A response that
// is still owed for the old PC is absorbed without being delivered.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active low
//   mem_req_o      fetch request, held until mem_valid_i
//   mem_addr_o     word-aligned fetch address, stable while mem_req_o=1
//   mem_valid_i    response valid (looked at only while mem_req_o=1)
//   mem_rdata_i    instruction word for mem_addr_o
//   redirect_i     flush and restart fetch at redirect_pc_i
//   redirect_pc_i  new PC (low two bits ignored)
//   instr_valid_o  FIFO head valid
//   instr_o        head instruction
//   instr_pc_o     PC of the head instruction
//   instr_ready_i  core takes the head when instr_valid_o=1
//   count_o        number of occupied FIFO entries
// -----------------------------------------------------------------------------
module fetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_valid_i,
  input  logic [31:0]              mem_rdata_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     instr_valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              instr_pc_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // ST_DRAIN: a request for a flushed PC is still outstanding and its
  // response must be swallowed before fetching at fetch_pc.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e          state_q,    state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            mem_req_q,  mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [31:0]     fifo_instr_d [DEPTH];
  logic [31:0]     fifo_pc_q    [DEPTH];
  logic [31:0]     fifo_pc_d    [DEPTH];

  logic            pop_s;
  logic            push_s;
  logic            flush_s;
  logic [31:0]     redirect_pc_s;
  logic [CW-1:0]   count_after_pop_s;
  logic [CW-1:0]   count_after_push_pop_s;

  // Pop qualification and the occupancy the issue decision looks at
  always_comb begin
    pop_s                  = (count_q != {CW{1'b0}}) & instr_ready_i;
    count_after_pop_s      = count_q - (pop_s ? ONE_C : {CW{1'b0}});
    count_after_push_pop_s = count_after_pop_s + ONE_C;
    redirect_pc_s          = redirect_pc_i & 32'hFFFF_FFFC;
  end

  // Fetch sequencer: next state, request/address and push/flush decisions
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push_s     = 1'b0;
    flush_s    = 1'b0;

    if (redirect_i) begin
      flush_s    = 1'b1;
      fetch_pc_d = redirect_pc_s;
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect_pc_s;
        end
        ST_REQ, ST_DRAIN: begin
          if (mem_valid_i) begin
            // Old response arrives with the redirect: drop it and
            // re-issue straight away at the new PC.
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = redirect_pc_s;
          end else begin
            // Keep the old request up until memory answers it.
            state_d    = ST_DRAIN;
            mem_req_d  = 1'b1;
            mem_addr_d = mem_addr_q;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (count_after_pop_s < DEPTH_C) begin
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
          end else begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end
        end
        ST_REQ: begin
          if (mem_valid_i) begin
            push_s     = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (count_after_push_pop_s < DEPTH_C) begin
              state_d    = ST_REQ;
              mem_req_d  = 1'b1;
              mem_addr_d = fetch_pc_q + 32'd4;
            end else begin
              state_d    = ST_IDLE;
              mem_req_d  = 1'b0;
              mem_addr_d = mem_addr_q;
            end
          end else begin
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = mem_addr_q;
          end
        end
        ST_DRAIN: begin
          if (mem_valid_i) begin
            // Stale word consumed; FIFO is empty so fetch resumes at once.
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
          end else begin
            state_d    = ST_DRAIN;
            mem_req_d  = 1'b1;
            mem_addr_d = mem_addr_q;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and storage update
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      fifo_instr_d[i] = fifo_instr_q[i];
      fifo_pc_d[i]    = fifo_pc_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_s) begin
      // The entry popped this cycle (if any) is still taken by the core.
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_instr_d[wr_ptr_q] = mem_rdata_i;
        fifo_pc_d[wr_ptr_q]    = mem_addr_q;
        wr_ptr_d               = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_after_pop_s + (push_s ? ONE_C : {CW{1'b0}});
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0000_0000;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= 32'h0000_0000;
        fifo_pc_q[i]    <= 32'h0000_0000;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= fifo_instr_d[i];
        fifo_pc_q[i]    <= fifo_pc_d[i];
      end
    end
  end

  // All outputs come straight from flops, so mem_* never reaches instr_*
  // combinationally.
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign instr_valid_o = (count_q != {CW{1'b0}});
  assign instr_o       = fifo_instr_q[rd_ptr_q];
  assign instr_pc_o    = fifo_pc_q[rd_ptr_q];
  assign count_o       = count_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for fetch_prefetch_unit: directed stimulus, a transaction-level
// model (queue of {pc,word} plus the outstanding-request view of the memory
// bus) checked every cycle, and hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [31:0] mem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [2:0]  count_o;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_valid_i   (mem_valid_i),
    .mem_rdata_i   (mem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Model state
  logic [63:0] q[$];
  bit          m_req;
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  bit          m_stale;
  bit          popped;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model, advanced on each rising edge
  always @(posedge clk) begin
    if (!rst_i) begin
      q.delete();
      m_req   = 1'b0;
      m_addr  = 32'h0;
      m_pc    = 32'h0;
      m_stale = 1'b0;
    end else begin
      popped = (q.size() != 0) && instr_ready_i;
      if (redirect_i) begin
        q.delete();
        m_pc = redirect_pc_i & 32'hFFFF_FFFC;
        if (!m_req) begin
          m_req = 1'b1; m_addr = m_pc; m_stale = 1'b0;
        end else if (mem_valid_i) begin
          m_addr = m_pc; m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end else if (m_req && mem_valid_i) begin
        if (m_stale) begin
          m_stale = 1'b0; m_addr = m_pc;
        end else begin
          if (popped) void'(q.pop_front());
          q.push_back({m_addr, mem_rdata_i});
          m_pc = m_addr + 32'd4;
          if (q.size() < DEPTH) m_addr = m_pc;
          else m_req = 1'b0;
        end
      end else begin
        if (popped) void'(q.pop_front());
        if (!m_req && q.size() < DEPTH) begin
          m_req = 1'b1; m_addr = m_pc;
        end
      end
    end
  end

  // Compare process: DUT vs model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", {31'd0, mem_req_o}, {31'd0, m_req});
      if (m_req) check("mem_addr", mem_addr_o, m_addr);
      check("count", {29'd0, count_o}, q.size());
      check("instr_valid", {31'd0, instr_valid_o}, (q.size() != 0) ? 32'd1 : 32'd0);
      if (q.size() != 0) begin
        check("instr", instr_o, q[0][31:0]);
        check("instr_pc", instr_pc_o, q[0][63:32]);
      end
    end
  end

  // Apply inputs for the next edge, then return 2 time units after it
  task automatic drive(input logic rst, input logic v, input logic rdy,
                       input logic rd, input logic [31:0] rpc);
    rst_i         = rst;
    mem_valid_i   = v;
    instr_ready_i = rdy;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    mem_rdata_i   = instr_of(mem_addr_o);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic expect_zero_outputs(input string tag);
    check({tag, "_req"},   {31'd0, mem_req_o}, 32'd0);
    check({tag, "_addr"},  mem_addr_o, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
    check({tag, "_instr"}, instr_o, 32'd0);
    check({tag, "_pc"},    instr_pc_o, 32'd0);
    check({tag, "_count"}, {29'd0, count_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b0; mem_valid_i = 1'b0; mem_rdata_i = 32'h0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; instr_ready_i = 1'b0;

    // Reset state
    do_reset();
    chk_en = 1'b1;
    expect_zero_outputs("rst");

    // 1: streaming with ready=1, 1-cycle memory
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check("t1_first_req", {31'd0, mem_req_o}, 32'd1);
    check("t1_addr0", mem_addr_o, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("t1_addr4", mem_addr_o, 32'h4);
    check("t1_pc0", instr_pc_o, 32'h0);
    check("t1_instr0", instr_o, 32'h1357_9BDF);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("t1_addr8", mem_addr_o, 32'h8);
    check("t1_pc4", instr_pc_o, 32'h4);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("t1_addr12", mem_addr_o, 32'hC);
    check("t1_count1", {29'd0, count_o}, 32'd1);

    // 2: ready=0 fills to DEPTH, then one pop re-issues at 16
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t2_full_count", {29'd0, count_o}, 32'd4);
    check("t2_full_noreq", {31'd0, mem_req_o}, 32'd0);
    check("t2_head_pc", instr_pc_o, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t2_idle_noreq", {31'd0, mem_req_o}, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check("t2_pop_count", {29'd0, count_o}, 32'd3);
    check("t2_reissue_req", {31'd0, mem_req_o}, 32'd1);
    check("t2_reissue_addr", mem_addr_o, 32'h10);
    check("t2_new_head", instr_pc_o, 32'h4);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t2_refull_noreq", {31'd0, mem_req_o}, 32'd0);
    // redirect while IDLE and full
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h43);
    check("t2_idle_redir_count", {29'd0, count_o}, 32'd0);
    check("t2_idle_redir_addr", mem_addr_o, 32'h40);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("t2_idle_redir_pc", instr_pc_o, 32'h40);

    // 3: redirect with request at 8 unanswered, then drain
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t3_addr8", mem_addr_o, 32'h8);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h103);
    check("t3_flushed", {29'd0, count_o}, 32'd0);
    check("t3_hold_addr", mem_addr_o, 32'h8);
    check("t3_hold_req", {31'd0, mem_req_o}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t3_hold_addr2", mem_addr_o, 32'h8);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_discard", {31'd0, instr_valid_o}, 32'd0);
    check("t3_new_addr", mem_addr_o, 32'h100);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t3_first_pc", instr_pc_o, 32'h100);
    check("t3_first_instr", instr_o, 32'h1357_9CDF ^ 32'h0000_0000 ^ (32'h300 ^ 32'h1357_9BDF ^ 32'h1357_9CDF));

    // 4: redirect coincident with the response for address 4
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t4_addr4", mem_addr_o, 32'h4);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h2000);
    check("t4_count0", {29'd0, count_o}, 32'd0);
    check("t4_addr_target", mem_addr_o, 32'h2000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t4_pc_target", instr_pc_o, 32'h2000);

    // 5: redirect into DRAIN, redirect again in DRAIN, PC wrap at 2^32
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h500);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    check("t5_drain_addr", mem_addr_o, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t5_top_addr", mem_addr_o, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t5_wrap_addr", mem_addr_o, 32'h0);
    check("t5_top_pc", instr_pc_o, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t5_after_wrap", mem_addr_o, 32'h4);

    // 6: reset with count=3, and reset in DRAIN
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t6_count3", {29'd0, count_o}, 32'd3);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h80);
    expect_zero_outputs("t6_rst");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t6_req_after", {31'd0, mem_req_o}, 32'd1);
    check("t6_addr_after", mem_addr_o, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h600);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    expect_zero_outputs("t6_drain_rst");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t6_drain_req_after", {31'd0, mem_req_o}, 32'd1);
    check("t6_drain_addr_after", mem_addr_o, 32'h0);

    // 7: mixed traffic, checked by the model every cycle
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, (i % 3) != 2, (i % 4) < 2,
            (i == 17) || (i == 38) || (i == 40),
            32'h0000_0201 + 32'(i) * 32'd8);
    end

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
